// File: rtl/darkuart_pkg.sv
// Shared types and constants for the darkuart receive path.
package darkuart_pkg;

    localparam int UART_DBITS       = 8;
    localparam int UART_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; head entry is presented whenever not empty.
module uart_rx_fifo
    import darkuart_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int DATA_W  = UART_DBITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic [FIFO_AW:0]  count
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   occ;
    logic               do_push;
    logic               do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == (FIFO_AW+1)'(DEPTH));
    assign count   = occ;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, sticky error flags and
// an output FIFO drained through a valid/ready port.
module uart_rx_decoder
    import darkuart_pkg::*;
#(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 3
) (
    input  logic       XCLK,
    input  logic       XRES,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_BUSY,
    output logic       FERR,
    output logic       OVR,
    input  logic       CLR
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(UART_DBITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DBITS - 1);

    logic [UART_SYNC_STAGES-1:0] rxd_sync;
    logic                        rxs;

    rx_state_t             state;
    rx_state_t             state_d;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_load;
    logic                  strobe;
    logic [IDX_W-1:0]      idx;
    logic                  idx_clr;
    logic                  shift_en;
    logic [UART_DBITS-1:0] shreg;
    logic                  push;
    logic                  ferr_set;
    logic                  ovr_set;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_AW:0]      fifo_count;
    logic                  fifo_pop;

    // Idle-high reset value keeps a reset release from looking like a start edge.
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) rxd_sync <= '1;
        else      rxd_sync <= {rxd_sync[UART_SYNC_STAGES-2:0], RXD};
    end

    assign rxs    = rxd_sync[UART_SYNC_STAGES-1];
    assign strobe = (cnt == '0);

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d      = state;
        cnt_load     = 1'b0;
        cnt_load_val = CNT_FULL;
        idx_clr      = 1'b0;
        shift_en     = 1'b0;
        push         = 1'b0;
        ferr_set     = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_d      = START;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_HALF;
                end
            end
            START: begin
                if (strobe) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        cnt_load = 1'b1;
                        idx_clr  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    if (idx == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives the next start edge half a bit of margin.
                if (strobe) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (cnt_load)        cnt <= cnt_load_val;
            else if (cnt != '0)  cnt <= cnt - 1'b1;
            if (idx_clr)         idx <= '0;
            else if (shift_en)   idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge XCLK) begin
        if (shift_en) shreg <= {rxs, shreg[UART_DBITS-1:1]};
    end

    assign fifo_pop = RX_READY && !fifo_empty;
    assign ovr_set  = push && fifo_full && !fifo_pop;

    // Set has priority over a coincident clear so no event is lost.
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            FERR <= 1'b0;
            OVR  <= 1'b0;
        end else begin
            FERR <= ferr_set | (FERR & ~CLR);
            OVR  <= ovr_set  | (OVR  & ~CLR);
        end
    end

    uart_rx_fifo #(
        .FIFO_AW (FIFO_AW),
        .DATA_W  (UART_DBITS)
    ) u_fifo (
        .clk       (XCLK),
        .rst       (XRES),
        .push      (push),
        .push_data (shreg),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (RX_DATA),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign RX_VALID = (fifo_count != '0);
    assign RX_BUSY  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder with a queue-based reference of received bytes and flags.
module tb_uart_rx_decoder;

    localparam int BD = 16;

    logic       XCLK = 1'b0;
    logic       XRES = 1'b1;
    logic       RXD = 1'b1;
    logic       RX_READY = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_BUSY;
    logic       FERR;
    logic       OVR;

    uart_rx_decoder #(.BAUD_DIV(BD), .FIFO_AW(3)) dut (
        .XCLK     (XCLK),
        .XRES     (XRES),
        .RXD      (RXD),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .RX_BUSY  (RX_BUSY),
        .FERR     (FERR),
        .OVR      (OVR),
        .CLR      (CLR)
    );

    always #5 XCLK = ~XCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    // Reference: bytes the consumer should see, sticky flags, and scheduled frame outcomes.
    byte unsigned mq[$];
    bit           m_ferr = 1'b0;
    bit           m_ovr  = 1'b0;
    int           ev_cyc[$];
    bit           ev_ferr[$];
    byte unsigned ev_dat[$];

    int    lit_cyc[$];
    int    lit_kind[$];
    int    lit_val[$];
    string lit_name[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic lit(input int c, input int kind, input int val, input string name);
        lit_cyc.push_back(c);
        lit_kind.push_back(kind);
        lit_val.push_back(val);
        lit_name.push_back(name);
    endtask

    // Reference update at each edge: pop, then clear, then frame outcomes (set beats clear).
    always @(posedge XCLK) begin
        if (!XRES) begin
            if (mq.size() > 0 && RX_READY) void'(mq.pop_front());
            if (CLR) begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            while (ev_cyc.size() > 0 && ev_cyc[0] == cyc + 1) begin
                if (ev_ferr[0])           m_ferr = 1'b1;
                else if (mq.size() == 8)  m_ovr  = 1'b1;
                else                      mq.push_back(ev_dat[0]);
                void'(ev_cyc.pop_front());
                void'(ev_ferr.pop_front());
                void'(ev_dat.pop_front());
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge XCLK) begin
        if (!XRES && chk_on) begin
            check("valid", RX_VALID, mq.size() > 0);
            if (mq.size() > 0) check("data", RX_DATA, mq[0]);
            check("ferr", FERR, m_ferr);
            check("ovr", OVR, m_ovr);
            for (int i = lit_cyc.size() - 1; i >= 0; i--) begin
                if (lit_cyc[i] == cyc) begin
                    case (lit_kind[i])
                        0:       check(lit_name[i], RX_VALID, lit_val[i]);
                        1:       check(lit_name[i], RX_DATA, lit_val[i]);
                        2:       check(lit_name[i], RX_BUSY, lit_val[i]);
                        3:       check(lit_name[i], FERR, lit_val[i]);
                        default: check(lit_name[i], OVR, lit_val[i]);
                    endcase
                    lit_cyc.delete(i);
                    lit_kind.delete(i);
                    lit_val.delete(i);
                    lit_name.delete(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge XCLK);
        #2;
    endtask

    // Iteration i runs in cycle n+i; the frame outcome is visible at n+155 (t0 = n+2).
    task automatic send_frame(input byte unsigned d, input bit stop, input int low_len,
                              input int pop_off, input int abort_at);
        int n;
        int len;
        len = stop ? 160 : 144 + low_len + 16;
        for (int i = 0; i < len; i++) begin
            tick();
            if (i == 0) begin
                n = cyc;
                if (abort_at < 0) begin
                    ev_cyc.push_back(n + 155);
                    ev_ferr.push_back(!stop);
                    ev_dat.push_back(d);
                end
            end
            if (i == abort_at) begin
                check("abort_busy_before", RX_BUSY, 1);
                check("abort_valid_before", RX_VALID, 1);
                XRES = 1'b1;
                RXD  = 1'b1;
                mq.delete();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
                #1;
                check("abort_valid", RX_VALID, 0);
                check("abort_data", RX_DATA, 0);
                check("abort_busy", RX_BUSY, 0);
                check("abort_ferr", FERR, 0);
                check("abort_ovr", OVR, 0);
                repeat (3) tick();
                XRES = 1'b0;
                return;
            end
            if (i < 16)                    RXD = 1'b0;
            else if (i < 144)              RXD = d[(i / 16) - 1];
            else if (stop)                 RXD = 1'b1;
            else if (i < 144 + low_len)    RXD = 1'b0;
            else                           RXD = 1'b1;
            if (pop_off >= 0) begin
                if (i == pop_off)     RX_READY = 1'b1;
                if (i == pop_off + 1) RX_READY = 1'b0;
            end
        end
        RXD = 1'b1;
    endtask

    task automatic pulse_clr();
        tick();
        CLR = 1'b1;
        lit(cyc + 1, 3, 0, "clr_ferr");
        lit(cyc + 1, 4, 0, "clr_ovr");
        tick();
        CLR = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_valid", RX_VALID, 0);
        check("rst_data", RX_DATA, 0);
        check("rst_busy", RX_BUSY, 0);
        check("rst_ferr", FERR, 0);
        check("rst_ovr", OVR, 0);
        XRES = 1'b0;
        chk_on = 1'b1;
        repeat (5) tick();

        // Single byte, consumer always ready
        RX_READY = 1'b1;
        n = cyc + 1;
        lit(n + 154, 0, 0, "t1_valid_pre");
        lit(n + 155, 0, 1, "t1_valid");
        lit(n + 155, 1, 8'h55, "t1_data");
        lit(n + 156, 0, 0, "t1_valid_post");
        lit(n + 2, 2, 0, "t1_busy_t0");
        lit(n + 3, 2, 1, "t1_busy_t1");
        lit(n + 154, 2, 1, "t1_busy_stop");
        lit(n + 155, 2, 0, "t1_busy_idle");
        send_frame(8'h55, 1'b1, 0, -1, -1);
        repeat (10) tick();

        // Back-to-back frames with no idle gap
        n = cyc + 1;
        lit(n + 157, 2, 0, "t2_busy_gap");
        lit(n + 163, 2, 1, "t2_busy_next");
        lit(n + 315, 1, 8'h42, "t2_data_42");
        lit(n + 475, 1, 8'h0D, "t2_data_0d");
        send_frame(8'h41, 1'b1, 0, -1, -1);
        send_frame(8'h42, 1'b1, 0, -1, -1);
        send_frame(8'h0D, 1'b1, 0, -1, -1);
        repeat (10) tick();

        // Short low glitch
        n = cyc + 1;
        lit(n + 9, 2, 1, "t3_busy_start");
        lit(n + 12, 2, 0, "t3_busy_idle");
        for (int i = 0; i < 4; i++) begin
            tick();
            RXD = 1'b0;
        end
        tick();
        RXD = 1'b1;
        repeat (180) tick();

        // Framing error followed by a held-low line
        n = cyc + 1;
        lit(n + 154, 3, 0, "t4_ferr_pre");
        lit(n + 155, 3, 1, "t4_ferr");
        lit(n + 180, 2, 1, "t4_wait_high");
        lit(n + 188, 2, 0, "t4_idle");
        send_frame(8'hA5, 1'b0, 40, -1, -1);
        repeat (5) tick();
        pulse_clr();
        repeat (5) tick();

        // Overrun with consumer stalled
        RX_READY = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) begin
                n = cyc + 1;
                lit(n + 154, 4, 0, "t5_ovr_pre");
                lit(n + 155, 4, 1, "t5_ovr");
                lit(n + 155, 1, 8'h00, "t5_head");
            end
            send_frame(byte'(k), 1'b1, 0, -1, -1);
        end
        repeat (5) tick();
        pulse_clr();
        n = cyc + 1;
        lit(n + 155, 4, 0, "t5_coinc_ovr");
        lit(n + 155, 1, 8'h01, "t5_coinc_head");
        send_frame(8'h09, 1'b1, 0, 154, -1);
        tick();
        RX_READY = 1'b1;
        repeat (20) tick();
        RX_READY = 1'b0;
        check("t5_drained", RX_VALID, 0);

        // Reset in the middle of a frame, then a clean frame
        send_frame(8'h5A, 1'b1, 0, -1, -1);
        repeat (4) tick();
        send_frame(8'hC3, 1'b1, 0, -1, 85);
        repeat (10) tick();
        RX_READY = 1'b1;
        n = cyc + 1;
        lit(n + 155, 1, 8'h3C, "t6_data");
        lit(n + 155, 0, 1, "t6_valid");
        send_frame(8'h3C, 1'b1, 0, -1, -1);
        repeat (20) tick();

        check("lits_pending", lit_cyc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
